time_set_ctrl: RTL and testbench
================================

// Module: time_set_ctrl
// PURPOSE
//  Time-setting controller for the digital clock. Takes the two push keys (MODE, UP) and sequences
//  RUN -> SET_HOUR -> SET_MIN -> RUN. Generates 1-cycle +1 pulses for the hour/minute counters' INC
//  inputs, gates the 1 Hz count enable while setting and clears seconds on exit. Provides per-field
//  blink enables for the 7-seg driver. Sits between the key inputs and the SEC/MIN/HOUR counter chain.
// PARAMETERS
//  DEB_TICKS   4    consecutive equal TICK samples needed to accept a key level change (>=1)
//  REPEAT_DLY  50   TICKs UP must stay held before auto-repeat starts (>=1)
//  REPEAT_PER  10   TICKs between auto-repeat pulses (>=1)
//  TIMEOUT     1000 TICKs with no accepted press in SET_* before forced return to RUN (>=1)
//  BLINK_HALF  25   TICKs per blink half-period (>=1)
// PORTS
//  CLK      in  1  system clock
//  RST      in  1  asynchronous, active-low reset (RST=0 resets)
//  TICK     in  1  1-cycle strobe, slow time base (e.g. 100 Hz); all timing counts in TICKs
//  MODE_N   in  1  MODE key, raw, asynchronous, active-low (0 = pressed)
//  UP_N     in  1  UP key, raw, asynchronous, active-low
//  RUN_EN   out 1  1 = pass 1 Hz enable to seconds counter; 0 in SET_HOUR/SET_MIN
//  CLR_SEC  out 1  1-cycle pulse: clear seconds counter on SET_MIN/timeout -> RUN
//  INC_HOUR out 1  1-cycle pulse: hour counter +1 (wraps 23->0 inside the counter)
//  INC_MIN  out 1  1-cycle pulse: minute counter +1 (no carry into hours)
//  BLINK_H  out 1  1 = blank hour digits this phase (SET_HOUR only)
//  BLINK_M  out 1  1 = blank minute digits this phase (SET_MIN only)
//  MODE_ST  out 2  state: 0 RUN, 1 SET_HOUR, 2 SET_MIN (3 never reached)
// BEHAVIOUR
//  Reset: state RUN; RUN_EN=1; CLR_SEC=INC_HOUR=INC_MIN=BLINK_H=BLINK_M=0; MODE_ST=0; all counters 0;
//   debounced levels = released. Reset at any time (mid-repeat, mid-setting) returns here at once.
//  Input path: each key through 2-FF synchroniser, then inverted to active-high. Debouncer samples only
//   on TICK; accepted level flips after DEB_TICKS consecutive samples differing from it; any agreeing
//   sample restarts the count. Press event = accepted 0->1 flip, 1 cycle, same cycle as the flip.
//  FSM (registered, advances on MODE press event):
//   RUN -> SET_HOUR -> SET_MIN -> RUN. On SET_MIN->RUN, CLR_SEC=1 for the next cycle.
//   Timeout: in SET_*, counter incremented on TICK, cleared on any accepted press (MODE or UP) and on
//    state entry; when it reaches TIMEOUT -> RUN with CLR_SEC pulse, INC outputs suppressed that cycle.
//   RUN_EN = (state==RUN), registered with state. UP presses in RUN are ignored (no INC, no repeat).
//  Increment: UP press event in SET_HOUR -> INC_HOUR=1 next cycle; in SET_MIN -> INC_MIN=1 next cycle.
//   Auto-repeat: while debounced UP stays pressed, repeat counter counts TICKs; at REPEAT_DLY issue
//   one INC pulse, then one every REPEAT_PER TICKs. Release, state change or MODE press clears it.
//   Auto-repeat pulses also clear the timeout counter. Max one INC pulse per cycle; never both INCs.
//  Simultaneous MODE and UP press events in one cycle: MODE wins, state advances, no INC issued, repeat cleared.
//  Blink: phase counter counts TICKs, toggles phase every BLINK_HALF; cleared to phase 0 (visible) on
//   state entry and on every INC pulse. BLINK_H = (state==SET_HOUR)&phase;
//   BLINK_M = (state==SET_MIN)&phase; both 0 in RUN.
//  Latency: key pin edge -> press event = 2 CLK + DEB_TICKS TICKs (+ up to 1 TICK period alignment);
//   press event -> INC/state/RUN_EN change = 1 CLK.
// TESTING (DEB_TICKS=2, REPEAT_DLY=4, REPEAT_PER=2, TIMEOUT=20, BLINK_HALF=3, TICK every 4 CLK)
//  Reset: RST=0 while holding UP_N=0 mid-repeat -> all outputs at reset values; after RST=1, no INC
//   until UP released and pressed again.
//  Mode cycle: 3 clean MODE presses -> MODE_ST 0->1->2->0; RUN_EN 1->0->0->1; exactly one CLR_SEC
//   pulse, in the cycle after MODE_ST returns to 0.
//  Bounce: in SET_HOUR, UP_N toggling every TICK for 10 TICKs, then stable 0 -> exactly 1 INC_HOUR
//   pulse, issued after 2 stable TICKs.
//  Repeat: in SET_MIN, hold UP_N=0 for 12 TICKs after acceptance -> INC_MIN at acceptance+1 CLK, then
//   at TICKs 4,6,8,10,12 (6 total); INC_HOUR never asserted; BLINK_M=0 right after each pulse.
//  Timeout: enter SET_HOUR, no keys -> MODE_ST=0 and CLR_SEC pulse after 20 TICKs; BLINK_H toggled
//   every 3 TICKs before that; a UP press at TICK 15 pushes timeout to TICK 35.
//  Collision: MODE and UP accepted in same cycle in SET_HOUR -> MODE_ST=2, no INC_HOUR/INC_MIN pulse.

Source files
------------

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: MODE/UP key sequencer RUN -> SET_HOUR -> SET_MIN -> RUN for the digital clock,
// with TICK-based debounce, UP auto-repeat, setting timeout and per-field blink enables.
module time_set_ctrl #(
    parameter int DEB_TICKS  = 4,
    parameter int REPEAT_DLY = 50,
    parameter int REPEAT_PER = 10,
    parameter int TIMEOUT    = 1000,
    parameter int BLINK_HALF = 25
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TICK,
    input  logic       MODE_N,
    input  logic       UP_N,
    output logic       RUN_EN,
    output logic       CLR_SEC,
    output logic       INC_HOUR,
    output logic       INC_MIN,
    output logic       BLINK_H,
    output logic       BLINK_M,
    output logic [1:0] MODE_ST
);
    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam int RW = $clog2((REPEAT_DLY > REPEAT_PER ? REPEAT_DLY : REPEAT_PER) + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BH_LAST  = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2} state_t;

    state_t state, state_nx;
    logic [1:0] sync0, sync1, key, lvl, lvl_nx;
    logic [1:0][DW-1:0] deb_cnt, deb_nx;
    logic [RW-1:0] rep_cnt, rep_nx;
    logic [TW-1:0] to_cnt, to_nx;
    logic [BW-1:0] ph_cnt, ph_nx;
    logic rep_rpt, rpt_nx, phase, phase_nx;
    logic press_mode, press_up, up_hold, setting;
    logic rep_fire, timeout, entry, inc, rep_clr, ph_clr, ph_wrap;

    // bit 0 = MODE, bit 1 = UP; pins idle high so the synchroniser resets to "released"
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync0   <= 2'b11;
            sync1   <= 2'b11;
            lvl     <= '0;
            deb_cnt <= '0;
        end else begin
            sync0   <= {UP_N, MODE_N};
            sync1   <= sync0;
            lvl     <= lvl_nx;
            deb_cnt <= deb_nx;
        end
    end

    assign key = ~sync1;

    always_comb begin
        lvl_nx = lvl;
        deb_nx = deb_cnt;
        for (int i = 0; i < 2; i++) begin
            if (TICK && key[i] != lvl[i]) begin
                lvl_nx[i] = deb_cnt[i] == DEB_LAST ? key[i] : lvl[i];
                deb_nx[i] = deb_cnt[i] == DEB_LAST ? '0 : deb_cnt[i] + 1'b1;
            end else if (TICK) begin
                deb_nx[i] = '0;
            end
        end
    end

    assign press_mode = ~lvl[0] & lvl_nx[0];
    assign press_up   = ~lvl[1] & lvl_nx[1];
    assign up_hold    = lvl_nx[1];
    assign setting    = state != RUN;

    always_comb begin
        rep_fire = setting && up_hold && !press_up && !press_mode && TICK &&
                   rep_cnt == (rep_rpt ? PER_LAST : DLY_LAST);
        timeout  = setting && TICK && !press_mode && !press_up && !rep_fire && to_cnt == TO_LAST;
        state_nx = state;
        if (press_mode) begin
            if (state == RUN) state_nx = SET_HOUR;
            else if (state == SET_HOUR) state_nx = SET_MIN;
            else state_nx = RUN;
        end else if (timeout) begin
            state_nx = RUN;
        end
        entry    = state_nx != state;
        inc      = setting && !press_mode && (press_up || rep_fire);
        rep_clr  = !setting || entry || !up_hold || press_up;
        rep_nx   = rep_clr || rep_fire ? '0 : TICK ? rep_cnt + 1'b1 : rep_cnt;
        rpt_nx   = !rep_clr && (rep_rpt || rep_fire);
        to_nx    = !setting || entry || press_up || rep_fire ? '0 : TICK ? to_cnt + 1'b1 : to_cnt;
        ph_clr   = !setting || entry || inc;
        ph_wrap  = TICK && ph_cnt == BH_LAST;
        ph_nx    = ph_clr || ph_wrap ? '0 : TICK ? ph_cnt + 1'b1 : ph_cnt;
        phase_nx = !ph_clr && (phase ^ ph_wrap);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= RUN;
            rep_cnt  <= '0;
            rep_rpt  <= 1'b0;
            to_cnt   <= '0;
            ph_cnt   <= '0;
            phase    <= 1'b0;
            RUN_EN   <= 1'b1;
            CLR_SEC  <= 1'b0;
            INC_HOUR <= 1'b0;
            INC_MIN  <= 1'b0;
        end else begin
            state    <= state_nx;
            rep_cnt  <= rep_nx;
            rep_rpt  <= rpt_nx;
            to_cnt   <= to_nx;
            ph_cnt   <= ph_nx;
            phase    <= phase_nx;
            RUN_EN   <= state_nx == RUN;
            CLR_SEC  <= setting && state_nx == RUN;
            INC_HOUR <= inc && state == SET_HOUR;
            INC_MIN  <= inc && state == SET_MIN;
        end
    end

    assign MODE_ST = state;
    assign BLINK_H = state == SET_HOUR && phase;
    assign BLINK_M = state == SET_MIN && phase;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed bench for time_set_ctrl with DEB 2, repeat 4/2, timeout 20, blink 3,
// TICK every 4 CLK; a negedge monitor counts output pulses, the main thread compares against hand values.
module tb_time_set_ctrl;
    logic clk = 1'b0, rst = 1'b0, tick = 1'b0, mode_n = 1'b1, up_n = 1'b1;
    logic run_en, clr_sec, inc_hour, inc_min, blink_h, blink_m;
    logic [1:0] mode_st;
    int n_chk = 0, n_err = 0, tick_no = 0, tc = 0;
    int nh = 0, nm = 0, nc = 0, ht = 0, bad_clr = 0, bad_blink = 0, both = 0;
    int mt[$];
    int a, e, s;
    int exp_off[6] = '{0, 4, 6, 8, 10, 12};

    time_set_ctrl #(
        .DEB_TICKS(2), .REPEAT_DLY(4), .REPEAT_PER(2), .TIMEOUT(20), .BLINK_HALF(3)
    ) dut (
        .CLK(clk), .RST(rst), .TICK(tick), .MODE_N(mode_n), .UP_N(up_n),
        .RUN_EN(run_en), .CLR_SEC(clr_sec), .INC_HOUR(inc_hour), .INC_MIN(inc_min),
        .BLINK_H(blink_h), .BLINK_M(blink_m), .MODE_ST(mode_st)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tc = (tc + 1) % 4;
            tick = tc == 0;
            if (tick) tick_no++;
        end
    end

    always @(negedge clk) begin
        if (inc_hour) begin
            nh++;
            ht = tick_no;
            if (blink_h) bad_blink++;
        end
        if (inc_min) begin
            nm++;
            mt.push_back(tick_no);
            if (blink_m) bad_blink++;
        end
        if (clr_sec) begin
            nc++;
            if (mode_st != 2'd0) bad_clr++;
        end
        if (inc_hour && inc_min) both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_until(input int t);
        while (tick_no < t) @(negedge clk);
        #1;
    endtask

    task automatic press_mode();
        mode_n = 1'b0;
        wait_until(tick_no + 3);
        mode_n = 1'b1;
        wait_until(tick_no + 3);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_st"}, mode_st, 0);
        check({tag, "_run_en"}, run_en, 1);
        check({tag, "_clr"}, clr_sec, 0);
        check({tag, "_inc_h"}, inc_hour, 0);
        check({tag, "_inc_m"}, inc_min, 0);
        check({tag, "_blink_h"}, blink_h, 0);
        check({tag, "_blink_m"}, blink_m, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (5) @(negedge clk);
        #1;
        check_reset("rst0");
        rst = 1'b1;
        wait_until(tick_no + 2);
        // mode cycle
        press_mode();
        check("cyc1_st", mode_st, 1);
        check("cyc1_run_en", run_en, 0);
        press_mode();
        check("cyc2_st", mode_st, 2);
        check("cyc2_run_en", run_en, 0);
        press_mode();
        check("cyc3_st", mode_st, 0);
        check("cyc3_run_en", run_en, 1);
        check("cyc_clr_cnt", nc, 1);
        check("cyc_clr_in_run", bad_clr, 0);
        check("cyc_no_inc", nh + nm, 0);
        // bounce in SET_HOUR
        press_mode();
        for (int i = 0; i < 10; i++) begin
            up_n = 1'(i % 2);
            wait_until(tick_no + 1);
        end
        up_n = 1'b0;
        s = tick_no;
        wait_until(s + 3);
        check("bounce_cnt", nh, 1);
        check("bounce_tick", ht, s + 2);
        up_n = 1'b1;
        wait_until(tick_no + 3);
        check("bounce_norep", nh, 1);
        check("bounce_st", mode_st, 1);
        // auto-repeat in SET_MIN
        press_mode();
        check("rep_st", mode_st, 2);
        up_n = 1'b0;
        a = tick_no + 2;
        wait_until(a + 12);
        up_n = 1'b1;
        wait_until(tick_no + 4);
        check("rep_cnt", nm, 6);
        for (int k = 0; k < 6; k++)
            check($sformatf("rep_off%0d", k), k < mt.size() ? mt[k] - a : -1, exp_off[k]);
        check("rep_no_hour", nh, 1);
        check("rep_blink", bad_blink, 0);
        press_mode();
        check("rep_exit_st", mode_st, 0);
        check("rep_exit_clr", nc, 2);
        // timeout without keys, blink phase
        mode_n = 1'b0;
        e = tick_no + 2;
        wait_until(e + 1);
        mode_n = 1'b1;
        wait_until(e + 3);
        check("blink_e3", blink_h, 0);
        wait_until(e + 4);
        check("blink_e4", blink_h, 1);
        wait_until(e + 7);
        check("blink_e7", blink_h, 0);
        wait_until(e + 10);
        check("blink_e10", blink_h, 1);
        wait_until(e + 20);
        check("to_e20_st", mode_st, 1);
        wait_until(e + 21);
        check("to_e21_st", mode_st, 0);
        check("to_clr", nc, 3);
        check("to_run_en", run_en, 1);
        // UP press at TICK 15 pushes the timeout out to TICK 35
        wait_until(tick_no + 2);
        mode_n = 1'b0;
        e = tick_no + 2;
        wait_until(e + 1);
        mode_n = 1'b1;
        wait_until(e + 13);
        up_n = 1'b0;
        wait_until(e + 15);
        up_n = 1'b1;
        wait_until(e + 21);
        check("to2_e21_st", mode_st, 1);
        wait_until(e + 35);
        check("to2_e35_st", mode_st, 1);
        wait_until(e + 36);
        check("to2_e36_st", mode_st, 0);
        check("to2_inc", nh, 2);
        check("to2_clr", nc, 4);
        // MODE and UP accepted together in SET_HOUR
        press_mode();
        check("col_pre_st", mode_st, 1);
        mode_n = 1'b0;
        up_n = 1'b0;
        wait_until(tick_no + 3);
        mode_n = 1'b1;
        up_n = 1'b1;
        wait_until(tick_no + 3);
        check("col_st", mode_st, 2);
        check("col_inc_h", nh, 2);
        check("col_inc_m", nm, 6);
        // reset while auto-repeating in SET_MIN
        up_n = 1'b0;
        wait_until(tick_no + 8);
        check("rst_pre_rep", nm, 8);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset("rst1");
        rst = 1'b1;
        wait_until(tick_no + 10);
        check("rst_hold_inc", nh + nm, 10);
        check("rst_hold_st", mode_st, 0);
        up_n = 1'b1;
        wait_until(tick_no + 3);
        up_n = 1'b0;
        wait_until(tick_no + 3);
        up_n = 1'b1;
        wait_until(tick_no + 3);
        check("run_up_ignored", nh + nm, 10);
        check("never_both", both, 0);
        check("clr_only_in_run", bad_clr, 0);
        check("blink_on_inc", bad_blink, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
